// File: rtl/pam4_frame_gen.sv
// pam4_frame_gen: N_CH-lane PAM4 frame source (comma header, per-lane PRBS payload, optional gap).
// Outputs registered from next-state with no bubble; no backpressure, send_stop aborts on the next edge.
module pam4_frame_gen #(
   parameter int N_CH        = 3,
   parameter int SYM_BITS    = 2,
   parameter int POLY_LENGTH = 9,
   parameter int POLY_TAP    = 5,
   parameter int INV_PATTERN = 1,
   parameter int HEAD_LENGTH = 10,
   parameter int GAP_LENGTH  = 4,
   parameter int LEN_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     send_enable,
   input  logic                     send_stop,
   input  logic [LEN_W-1:0]         payload_len,
   output logic [N_CH*SYM_BITS-1:0] data_out,
   output logic                     valid,
   output logic                     sof,
   output logic                     sop,
   output logic                     eof,
   output logic                     busy,
   output logic [LEN_W-1:0]         frame_cnt
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HEAD    = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_GAP     = 2'd3;

   localparam logic             INV       = (INV_PATTERN != 0);
   localparam logic [LEN_W-1:0] HEAD_LAST = LEN_W'(HEAD_LENGTH - 1);
   localparam logic [LEN_W-1:0] GAP_LAST  = (GAP_LENGTH > 0) ? LEN_W'(GAP_LENGTH - 1) : '0;

   typedef logic [POLY_LENGTH:1]                lfsr_t;
   typedef logic [N_CH-1:0][POLY_LENGTH:1]      lfsr_bank_t;

   if (N_CH >= (2 ** POLY_LENGTH) - 1) begin : g_bad_nch
      $error("pam4_frame_gen: N_CH must be less than 2**POLY_LENGTH-1");
   end
   if (HEAD_LENGTH < 2) begin : g_bad_head
      $error("pam4_frame_gen: HEAD_LENGTH must be at least 2");
   end
   if (POLY_TAP < 1 || POLY_TAP >= POLY_LENGTH) begin : g_bad_tap
      $error("pam4_frame_gen: POLY_TAP must lie in 1..POLY_LENGTH-1");
   end

   function automatic lfsr_bank_t seed_bank();
      lfsr_bank_t b;
      for (int c = 0; c < N_CH; c++) begin
         b[c] = {POLY_LENGTH{1'b1}} ^ lfsr_t'(c);
      end
      return b;
   endfunction

   localparam lfsr_bank_t SEEDS = seed_bank();

   function automatic lfsr_t lfsr_adv(input lfsr_t s);
      lfsr_t t;
      t = s;
      for (int b = 0; b < SYM_BITS; b++) begin
         t = {t[POLY_LENGTH-1:1], t[POLY_LENGTH] ^ t[POLY_TAP]};
      end
      return t;
   endfunction

   // First bit generated in a cycle lands in the symbol MSB.
   function automatic logic [SYM_BITS-1:0] lfsr_sym(input lfsr_t s);
      lfsr_t                t;
      logic                 n;
      logic [SYM_BITS-1:0]  y;
      t = s;
      y = '0;
      for (int b = SYM_BITS - 1; b >= 0; b--) begin
         n    = t[POLY_LENGTH] ^ t[POLY_TAP];
         y[b] = n ^ INV;
         t    = {t[POLY_LENGTH-1:1], n};
      end
      return y;
   endfunction

   logic [1:0]              state_q, state_n;
   logic [LEN_W-1:0]        cnt_q, cnt_n;
   logic [LEN_W-1:0]        len_q, len_n;
   logic [LEN_W-1:0]        fcnt_n;
   lfsr_bank_t              lfsr_q, lfsr_n, lfsr_step;
   logic [N_CH*SYM_BITS-1:0] prbs_sym, data_n;
   logic [SYM_BITS-1:0]     hdr_sym;
   logic                    start, finish, reload;

   always_comb begin
      lfsr_step = lfsr_q;
      prbs_sym  = '0;
      for (int c = 0; c < N_CH; c++) begin
         lfsr_step[c]                      = lfsr_adv(lfsr_q[c]);
         prbs_sym[c*SYM_BITS +: SYM_BITS]  = lfsr_sym(lfsr_q[c]);
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      len_n   = len_q;
      fcnt_n  = frame_cnt;
      start   = 1'b0;
      finish  = 1'b0;
      if (send_stop) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
      end else begin
         case (state_q)
            ST_IDLE: start = send_enable;
            ST_HEAD: begin
               if (cnt_q == HEAD_LAST) begin
                  state_n = ST_PAYLOAD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + LEN_W'(1);
               end
            end
            ST_PAYLOAD: begin
               // Continuous mode parks the index at 1 so sop never re-fires on wrap.
               if (len_q == '0) begin
                  cnt_n = LEN_W'(1);
               end else if (cnt_q == len_q - LEN_W'(1)) begin
                  fcnt_n = frame_cnt + LEN_W'(1);
                  if (GAP_LENGTH > 0) begin
                     state_n = ST_GAP;
                     cnt_n   = '0;
                  end else begin
                     finish = 1'b1;
                  end
               end else begin
                  cnt_n = cnt_q + LEN_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  finish = 1'b1;
               end else begin
                  cnt_n = cnt_q + LEN_W'(1);
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end

      reload = start || (finish && send_enable);
      if (reload) begin
         state_n = ST_HEAD;
         cnt_n   = '0;
         len_n   = payload_len;
      end else if (finish) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
      end
   end

   always_comb begin
      lfsr_n  = lfsr_q;
      data_n  = '0;
      hdr_sym = {SYM_BITS{cnt_n[1]}};
      if (reload) begin
         lfsr_n = SEEDS;
      end else if (state_n == ST_PAYLOAD) begin
         lfsr_n = lfsr_step;
         data_n = prbs_sym;
      end
      if (state_n == ST_HEAD) begin
         data_n = {N_CH{hdr_sym}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         lfsr_q    <= SEEDS;
         data_out  <= '0;
         valid     <= 1'b0;
         sof       <= 1'b0;
         sop       <= 1'b0;
         eof       <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         len_q     <= len_n;
         lfsr_q    <= lfsr_n;
         data_out  <= data_n;
         valid     <= (state_n == ST_HEAD) || (state_n == ST_PAYLOAD);
         sof       <= (state_n == ST_HEAD) && (cnt_n == '0);
         sop       <= (state_n == ST_PAYLOAD) && (cnt_n == '0);
         eof       <= (state_n == ST_PAYLOAD) && (len_n != '0) && (cnt_n == len_n - LEN_W'(1));
         busy      <= (state_n != ST_IDLE);
         frame_cnt <= fcnt_n;
      end
   end

endmodule

// File: tb/tb_pam4_frame_gen.sv
// Bench for pam4_frame_gen: default instance plus a GAP_LENGTH=0 instance, scoreboard-checked.
module tb_pam4_frame_gen;

   typedef struct {
      int          cyc;
      int          tst;
      logic [5:0]  d;
      logic        v, so, sp, eo, b;
      logic [15:0] fc;
   } exp_t;

   typedef struct {
      logic        r, en, st;
      logic [15:0] len;
      logic [5:0]  d;
      logic        v, so, sp, eo, b;
   } vec_t;

   logic        clk;
   logic        rst0, en0, stop0, rst1, en1, stop1;
   logic [15:0] len0, len1;
   logic [5:0]  d0, d1;
   logic        v0, sof0, sop0, eof0, busy0;
   logic        v1, sof1, sop1, eof1, busy1;
   logic [15:0] fc0, fc1;

   int          cyc;
   int          tst;
   int          checks;
   int          errors;
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        me;
   int unsigned ms[3];
   vec_t        vt[14];

   pam4_frame_gen dut0 (
      .clk(clk), .rst(rst0), .send_enable(en0), .send_stop(stop0), .payload_len(len0),
      .data_out(d0), .valid(v0), .sof(sof0), .sop(sop0), .eof(eof0), .busy(busy0), .frame_cnt(fc0)
   );

   pam4_frame_gen #(.GAP_LENGTH(0)) dut1 (
      .clk(clk), .rst(rst1), .send_enable(en1), .send_stop(stop1), .payload_len(len1),
      .data_out(d1), .valid(v1), .sof(sof1), .sop(sop1), .eof(eof1), .busy(busy1), .frame_cnt(fc1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compare(input int w, input exp_t e, input logic [5:0] d, input logic v,
                          input logic so, input logic sp, input logic eo, input logic b,
                          input logic [15:0] fc);
      checks++;
      if ({d, v, so, sp, eo, b, fc} !== {e.d, e.v, e.so, e.sp, e.eo, e.b, e.fc}) begin
         errors++;
         $display("FAIL dut%0d test%0d cyc%0d: got d=%h v=%b sof=%b sop=%b eof=%b busy=%b fc=%0d, want d=%h v=%b sof=%b sop=%b eof=%b busy=%b fc=%0d",
                  w, e.tst, e.cyc, d, v, so, sp, eo, b, fc, e.d, e.v, e.so, e.sp, e.eo, e.b, e.fc);
      end
   endtask

   // Scoreboard monitor: pops the expectation stamped for the edge just taken.
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (q0.size() > 0 && q0[0].cyc == cyc) begin
            me = q0.pop_front();
            compare(0, me, d0, v0, sof0, sop0, eof0, busy0, fc0);
         end
         if (q1.size() > 0 && q1[0].cyc == cyc) begin
            me = q1.pop_front();
            compare(1, me, d1, v1, sof1, sop1, eof1, busy1, fc1);
         end
      end
   end

   task automatic drive(input int w, input logic r, input logic en, input logic st,
                        input logic [15:0] len, input logic [5:0] d, input logic v,
                        input logic so, input logic sp, input logic eo, input logic b,
                        input logic [15:0] fc);
      exp_t e;
      if (w == 0) begin
         rst0 = r; en0 = en; stop0 = st; len0 = len;
      end else begin
         rst1 = r; en1 = en; stop1 = st; len1 = len;
      end
      e.cyc = cyc + 1; e.tst = tst; e.d = d; e.v = v; e.so = so; e.sp = sp;
      e.eo = eo; e.b = b; e.fc = fc;
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic mreseed();
      for (int c = 0; c < 3; c++) ms[c] = 32'h1FF ^ c;
   endtask

   task automatic mnext(output logic [5:0] s);
      int unsigned n;
      s = '0;
      for (int c = 0; c < 3; c++) begin
         for (int k = 1; k >= 0; k--) begin
            n            = ((ms[c] >> 8) ^ (ms[c] >> 4)) & 32'd1;
            ms[c]        = ((ms[c] << 1) | n) & 32'h1FF;
            s[c*2 + k]   = ~n[0];
         end
      end
   endtask

   // One frame: header entry, 9 more header symbols, npay payload symbols, gap cycles of zeros.
   task automatic frame(input int w, input int gap, input logic [15:0] len, input int npay,
                        input logic [15:0] fc, input logic hold);
      logic [5:0] s;
      mreseed();
      drive(w, 1'b0, 1'b1, 1'b0, len, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, fc);
      for (int i = 1; i < 10; i++) begin
         drive(w, 1'b0, hold, 1'b0, 16'd9, ((i & 2) != 0) ? 6'h3F : 6'h00,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fc);
      end
      for (int j = 0; j < npay; j++) begin
         mnext(s);
         drive(w, 1'b0, hold, 1'b0, 16'd9, s, 1'b1, 1'b0, j == 0,
               (len != 16'd0) && (j == npay - 1), 1'b1, fc);
      end
      for (int g = 0; g < gap; g++) begin
         drive(w, 1'b0, hold, 1'b0, 16'd9, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fc + 16'd1);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic en, input logic st, input logic [15:0] len,
                               input logic [5:0] d, input logic v, input logic so, input logic sp,
                               input logic eo, input logic b);
      vec_t x;
      x.r = r; x.en = en; x.st = st; x.len = len; x.d = d;
      x.v = v; x.so = so; x.sp = sp; x.eo = eo; x.b = b;
      return x;
   endfunction

   initial begin
      logic [5:0] s;
      tst = 0; checks = 0; errors = 0;
      rst0 = 1'b1; en0 = 1'b0; stop0 = 1'b0; len0 = '0;
      rst1 = 1'b1; en1 = 1'b0; stop1 = 1'b0; len1 = '0;

      vt[0] = mk(1'b1, 1'b0, 1'b0, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[1] = mk(1'b1, 1'b1, 1'b0, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[2] = mk(1'b0, 1'b1, 1'b1, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[3] = mk(1'b0, 1'b0, 1'b0, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[4] = mk(1'b0, 1'b1, 1'b0, 16'd0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i < 10; i++) begin
         vt[4+i] = mk(1'b0, 1'b0, 1'b0, 16'd7, ((i & 2) != 0) ? 6'h3F : 6'h00,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      end

      @(posedge clk);
      #1;
      drive(1, 1'b1, 1'b0, 1'b0, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Reset, stop-beats-enable in IDLE, then the continuous-mode header.
      for (int i = 0; i < 14; i++) begin
         drive(0, vt[i].r, vt[i].en, vt[i].st, vt[i].len, vt[i].d, vt[i].v,
               vt[i].so, vt[i].sp, vt[i].eo, vt[i].b, 16'd0);
      end

      // Continuous payload long enough to wrap the PRBS9 period on every lane.
      tst = 1;
      mreseed();
      for (int k = 0; k < 520; k++) begin
         mnext(s);
         drive(0, 1'b0, 1'b0, 1'b0, 16'd7, s, 1'b1, 1'b0, k == 0, 1'b0, 1'b1, 16'd0);
      end
      drive(0, 1'b0, 1'b0, 1'b1, 16'd7, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      drive(0, 1'b0, 1'b0, 1'b0, 16'd7, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Framed auto-repeat, payload_len wiggled mid-frame.
      tst = 2;
      frame(0, 4, 16'd5, 5, 16'd0, 1'b1);
      frame(0, 4, 16'd5, 5, 16'd1, 1'b1);
      frame(0, 4, 16'd5, 5, 16'd2, 1'b1);
      drive(0, 1'b0, 1'b0, 1'b0, 16'd5, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);

      // Stop landing on the eof cycle must not count the frame.
      tst = 4;
      frame(0, 0, 16'd3, 3, 16'd3, 1'b1);
      drive(0, 1'b0, 1'b1, 1'b1, 16'd3, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
      drive(0, 1'b0, 1'b0, 1'b0, 16'd3, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);

      // Reset mid-payload, then a fresh frame replays the original sequence.
      tst = 5;
      frame(0, 0, 16'd0, 6, 16'd3, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      frame(0, 0, 16'd0, 12, 16'd0, 1'b0);
      drive(0, 1'b0, 1'b0, 1'b1, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Zero-gap instance: one-symbol payloads back to back.
      tst = 6;
      frame(1, 0, 16'd1, 1, 16'd0, 1'b1);
      frame(1, 0, 16'd1, 1, 16'd1, 1'b1);
      drive(1, 1'b0, 1'b0, 1'b0, 16'd1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

      @(posedge clk);
      #3;
      @(posedge clk);
      #3;
      checks++;
      if (q0.size() + q1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q0.size() + q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pam4_frame_gen.md
Name: pam4_frame_gen

Overview:
Multi-channel PAM4 frame generator and parametrised successor to the single-lane header+PRBS source. Each frame emits a fixed comma header followed by an independent PRBS payload per channel (e.g. R/G/B lanes), then an optional gap. Frames are fixed-length and auto-repeating, or continuous until stopped. The block sits ahead of the per-lane PAM4 DAC mappers and contains its own LFSRs, so it has no external PRBS instance.

Parameters:
N_CH, 3, number of parallel channels
SYM_BITS, 2, bits per symbol (2 = PAM4)
POLY_LENGTH, 9, LFSR length L
POLY_TAP, 5, feedback tap T, polynomial x^L + x^T + 1
INV_PATTERN, 1, 1 = invert generated PRBS bits
HEAD_LENGTH, 10, header symbols per frame (>=2)
GAP_LENGTH, 4, zero symbols between frames in framed mode (0 allowed)
LEN_W, 16, width of payload_len and frame_cnt

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
send_enable  in  1  start a frame; held high = auto-repeat in framed mode
send_stop  in  1  abort/stop, highest priority
payload_len  in  LEN_W  payload symbols per frame; 0 = continuous
data_out  out  N_CH*SYM_BITS  channel c at [c*SYM_BITS +: SYM_BITS]
valid  out  1  data_out carries header or payload
sof  out  1  first header symbol
sop  out  1  first payload symbol
eof  out  1  last payload symbol (framed mode only)
busy  out  1  state != IDLE
frame_cnt  out  LEN_W  completed framed payloads, wraps

Behaviour:
- Reset (rst=1 at an edge): state IDLE, all counters 0, data_out=0, valid/sof/sop/eof/busy=0, frame_cnt=0, every LFSR reloaded with its seed.
- All outputs are registered from next-state logic. The symbol for the state entered at an edge appears on that same edge, so there is no bubble.
- States: IDLE, HEAD, PAYLOAD, GAP.
- IDLE: data_out=0, valid=0. If send_enable=1 and send_stop=0, go to HEAD at sym index 0. Latch payload_len into len_q. Reload all LFSRs.
- HEAD, symbol i = 0..HEAD_LENGTH-1: every channel outputs 0 when i[1]==0, else {SYM_BITS{1}}. valid=1, sof=1 only at i=0. After i=HEAD_LENGTH-1, go to PAYLOAD.
- PAYLOAD: each channel outputs its PRBS symbol; its LFSR advances SYM_BITS steps per cycle. valid=1, sop=1 on the first payload cycle.
  - len_q=0: remain in PAYLOAD until send_stop.
  - len_q>0: after len_q symbols, eof=1 on the last one and frame_cnt increments (wraps at 2^LEN_W). Then go to GAP, or straight to the HEAD/IDLE decision below if GAP_LENGTH=0.
- GAP: data_out=0, valid=0, busy=1 for GAP_LENGTH cycles. Then:
  - send_enable=1: go to HEAD, relatch payload_len, reload LFSRs.
  - otherwise: go to IDLE.
- LFSR step, state s[L:1]:
  - n = s[L]^s[T]; s <= {s[L-1:1], n}; output bit = n ^ INV_PATTERN.
  - The first bit generated in a cycle is the symbol MSB.
  - Seed for channel c = {L{1'b1}} ^ c. N_CH must be < 2^L-1; this is a parameter check at elaboration.
- send_stop=1 in any non-IDLE state: next edge goes to IDLE, outputs zeroed, and frame_cnt is not incremented even if that was the eof cycle. send_stop together with send_enable in IDLE: stay IDLE.
- payload_len changes mid-frame are ignored until the next latch.
- rst mid-frame: immediate return to reset values, frame_cnt cleared.

Test Plan:
1. Defaults, rst then send_enable pulse, payload_len=0 -> cycles 1..10 show per-channel header 0,0,3,3,0,0,3,3,0,0 with sof on cycle 1 only. Cycle 11 has sop=1, and channel 0's first symbol is 3 (PRBS9 all-ones seed, inverted). Continues until send_stop, then IDLE with data_out=0 next cycle.
2. payload_len=5, send_enable held -> 10 header + 5 payload symbols (eof on the 5th), then 4 gap zeros with valid=0, then a new sof. frame_cnt reaches 1, 2, 3 over three frames. Channel 0 PRBS restarts identically each frame.
3. Channel independence, N_CH=3 -> a 511-cycle PRBS9 payload per channel matches the reference model for seeds 0x1FF, 0x1FE, 0x1FD. Channels differ from each other, and each sequence repeats with period 511 bit-steps.
4. send_stop on the eof cycle of a framed payload -> IDLE on the next edge, frame_cnt unchanged. send_enable together with send_stop in IDLE -> stays IDLE, busy=0.
5. rst asserted mid-PAYLOAD, then send_enable -> outputs zero and frame_cnt=0 after reset. The new frame's PRBS equals the test-1 sequence.
6. GAP_LENGTH=0, payload_len=1, send_enable held -> header, one payload symbol with sop=eof=1, then sof the immediately following cycle. send_enable dropped after eof -> IDLE.
